// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP frame capture sequencer.
// Contents:
//   state_t    - sequencer states
//   PIX_W      - pixel width (RGB565)
//   FRAME_PIX  - pixels per frame at the default 640x480 geometry
//   frame_pix  - pixels per frame for an arbitrary geometry
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SKIP   = 3'd2,
    ST_CAPT   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam int PIX_W     = 16;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int FRAME_PIX = H_ACT_DEF * V_ACT_DEF;

  function automatic int frame_pix(input int h_act, input int v_act);
    return h_act * v_act;
  endfunction

endpackage

// File: rtl/dvp_bank_mgr.sv
// Ping-pong bank bookkeeping for the frame capture sequencer.
// Ports:
//   PCLK, Rst_n  - pixel clock, async active-low reset
//   commit       - one-cycle: current bank (ptr) now holds a complete frame
//   drop         - one-cycle: a frame was dropped for lack of a free bank
//   rel          - per-bank release pulses from the consumer
//   ptr          - bank the next captured frame goes to
//   full         - per-bank ownership flags (1 = owned by consumer)
//   drop_cnt     - saturating count of dropped frames
module dvp_bank_mgr (
  input  logic       PCLK,
  input  logic       Rst_n,
  input  logic       commit,
  input  logic       drop,
  input  logic [1:0] rel,
  output logic       ptr,
  output logic [1:0] full,
  output logic [7:0] drop_cnt
);

  logic [1:0] set_mask;

  assign set_mask = commit ? (ptr ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr      <= 1'b0;
      full     <= 2'b00;
      drop_cnt <= 8'd0;
    end else begin
      // A release that lands on the commit cycle of the same bank loses:
      // the freshly committed frame must not be handed back as free.
      full <= (full & ~rel) | set_mask;
      if (commit) begin
        ptr <= ~ptr;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dvp_frame_ctrl.sv
// Frame-level capture sequencer behind the DVP byte-to-pixel stage.
// Arms on Start, skips SkipFrames frames, then writes whole frames into a
// two-bank frame buffer, dropping frames while both banks are owned by the
// consumer.
// Ports:
//   PCLK, Rst_n              - pixel clock, async active-low reset
//   Start, Stop              - arm / abort commands (Stop wins)
//   Continuous, SkipFrames   - mode, latched on an accepted Start
//   In_Valid, In_Pixel, In_Vs- pixel stream and frame-active level
//   Rel_Bank                 - per-bank release pulses from the consumer
//   Wr_En/Wr_Bank/Wr_Addr/Wr_Data - buffer write port, one cycle after pixel
//   Frame_Done, Done_Bank    - commit notification
//   Short_Frame, Ovf         - sticky frame-size errors
//   Drop_Cnt, Bank_Full, Busy- status
//
// state  | meaning
// IDLE   | disarmed, waiting for Start
// WAIT   | armed, waiting for a frame start
// SKIP   | discarding the current frame (skip or drop), waiting for frame end
// CAPT   | writing the current frame into bank ptr
// COMMIT | one cycle: hand bank ptr to the consumer, flip ptr
module dvp_frame_ctrl
  import dvp_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int ADDR_W = 19
) (
  input  logic              PCLK,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Continuous,
  input  logic [3:0]        SkipFrames,
  input  logic              In_Valid,
  input  logic [PIX_W-1:0]  In_Pixel,
  input  logic              In_Vs,
  input  logic [1:0]        Rel_Bank,
  output logic              Wr_En,
  output logic              Wr_Bank,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [PIX_W-1:0]  Wr_Data,
  output logic              Frame_Done,
  output logic              Done_Bank,
  output logic              Short_Frame,
  output logic              Ovf,
  output logic [7:0]        Drop_Cnt,
  output logic [1:0]        Bank_Full,
  output logic              Busy
);

  // One spare bit so the count can sit at FRAME_PIX even when the frame
  // exactly fills the address space.
  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FPIX   = CNT_W'(frame_pix(H_ACT, V_ACT));

  state_t           state, state_nx;
  logic             vs_d;
  logic             fs, fe;
  logic             cont_q;
  logic [3:0]       skip_cnt;
  logic [CNT_W-1:0] count;
  logic             ptr;
  logic             arm, skip_dec, drop, cap_start, commit;
  logic             accept, room;

  assign fs     = In_Vs & ~vs_d;
  assign fe     = ~In_Vs & vs_d;
  assign accept = (state == ST_CAPT) && In_Valid && !Stop;
  assign room   = (count < FPIX);
  assign Busy   = (state != ST_IDLE);

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Stop overrides everything, including the COMMIT cycle, so an aborted
  // frame never reaches the consumer.
  always_comb begin
    state_nx  = state;
    arm       = 1'b0;
    skip_dec  = 1'b0;
    drop      = 1'b0;
    cap_start = 1'b0;
    commit    = 1'b0;
    if (Stop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            arm      = 1'b1;
            state_nx = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fs) begin
            if (skip_cnt != 4'd0) begin
              skip_dec = 1'b1;
              state_nx = ST_SKIP;
            end else if (!Bank_Full[ptr]) begin
              cap_start = 1'b1;
              state_nx  = ST_CAPT;
            end else begin
              drop     = 1'b1;
              state_nx = ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (fe) state_nx = ST_WAIT;
        end
        ST_CAPT: begin
          if (fe) state_nx = ST_COMMIT;
        end
        ST_COMMIT: begin
          commit   = 1'b1;
          state_nx = cont_q ? ST_WAIT : ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_d        <= 1'b0;
      cont_q      <= 1'b0;
      skip_cnt    <= 4'd0;
      count       <= '0;
      Wr_En       <= 1'b0;
      Wr_Bank     <= 1'b0;
      Wr_Addr     <= '0;
      Wr_Data     <= '0;
      Frame_Done  <= 1'b0;
      Done_Bank   <= 1'b0;
      Short_Frame <= 1'b0;
      Ovf         <= 1'b0;
    end else begin
      vs_d <= In_Vs;

      if (arm) begin
        cont_q   <= Continuous;
        skip_cnt <= SkipFrames;
      end else if (skip_dec) begin
        skip_cnt <= skip_cnt - 4'd1;
      end

      Wr_En <= accept && room;
      if (cap_start) begin
        count <= '0;
      end else if (accept && room) begin
        Wr_Bank <= ptr;
        Wr_Addr <= count[ADDR_W-1:0];
        Wr_Data <= In_Pixel;
        count   <= count + CNT_W'(1);
      end
      if (accept && !room) begin
        Ovf <= 1'b1;
      end

      Frame_Done <= commit;
      if (commit) begin
        Done_Bank <= ptr;
        if (!room) begin
        end else begin
          Short_Frame <= 1'b1;
        end
      end
    end
  end

  dvp_bank_mgr u_bank_mgr (
    .PCLK     (PCLK),
    .Rst_n    (Rst_n),
    .commit   (commit),
    .drop     (drop),
    .rel      (Rel_Bank),
    .ptr      (ptr),
    .full     (Bank_Full),
    .drop_cnt (Drop_Cnt)
  );

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
module tb_dvp_frame_ctrl;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 4;
  localparam int FP = H * V;

  logic          PCLK = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic          Continuous = 1'b0;
  logic [3:0]    SkipFrames = 4'd0;
  logic          In_Valid = 1'b0;
  logic [15:0]   In_Pixel = 16'd0;
  logic          In_Vs = 1'b0;
  logic [1:0]    Rel_Bank = 2'b00;
  logic          Wr_En, Wr_Bank, Frame_Done, Done_Bank, Short_Frame, Ovf, Busy;
  logic [AW-1:0] Wr_Addr;
  logic [15:0]   Wr_Data;
  logic [7:0]    Drop_Cnt;
  logic [1:0]    Bank_Full;

  always #5 PCLK = ~PCLK;

  dvp_frame_ctrl #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
    .PCLK(PCLK), .Rst_n(Rst_n), .Start(Start), .Stop(Stop),
    .Continuous(Continuous), .SkipFrames(SkipFrames),
    .In_Valid(In_Valid), .In_Pixel(In_Pixel), .In_Vs(In_Vs),
    .Rel_Bank(Rel_Bank), .Wr_En(Wr_En), .Wr_Bank(Wr_Bank),
    .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Frame_Done(Frame_Done),
    .Done_Bank(Done_Bank), .Short_Frame(Short_Frame), .Ovf(Ovf),
    .Drop_Cnt(Drop_Cnt), .Bank_Full(Bank_Full), .Busy(Busy)
  );

  typedef struct packed { logic bank; logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic bank; logic short_f; } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    finished = 0;

  // Frame-level reference model of the sequencer.
  bit       m_armed, m_cont, m_ptr, m_ovf, m_short;
  int       m_skip, m_drop;
  bit [1:0] m_full;

  task automatic model_reset();
    m_armed = 0; m_cont = 0; m_ptr = 0; m_ovf = 0; m_short = 0;
    m_skip = 0; m_drop = 0; m_full = 2'b00;
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Scoreboard monitor: consumes expected writes and commits as the DUT shows them.
  always @(negedge PCLK) begin
    wr_t   ew;
    done_t ed;
    if (Rst_n) begin
      if (Wr_En) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got bank %0d addr %0d expected no write", Wr_Bank, Wr_Addr);
        end else begin
          ew = wr_q.pop_front();
          check("wr_bank", 32'(Wr_Bank), 32'(ew.bank));
          check("wr_addr", 32'(Wr_Addr), 32'(ew.addr));
          check("wr_data", 32'(Wr_Data), 32'(ew.data));
        end
      end
      if (Frame_Done) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_done: got bank %0d expected no commit", Done_Bank);
        end else begin
          ed = done_q.pop_front();
          check("done_bank", 32'(Done_Bank), 32'(ed.bank));
          check("short_frame_at_done", 32'(Short_Frame), 32'(ed.short_f));
          check("bank_full_at_done", 32'(Bank_Full[Done_Bank]), 32'd1);
        end
      end
    end
  end

  task automatic do_reset();
    Rst_n = 0;
    tick(); tick();
    Rst_n = 1;
    model_reset();
    tick();
  endtask

  task automatic do_start(input bit cont, input int skip);
    Continuous = cont;
    SkipFrames = 4'(skip);
    Start = 1; tick(); Start = 0;
    if (!m_armed) begin
      m_armed = 1; m_cont = cont; m_skip = skip;
    end
  endtask

  task automatic do_release(input logic [1:0] mask);
    Rel_Bank = mask; tick(); Rel_Bank = 2'b00;
    m_full = m_full & ~mask;
  endtask

  // One frame of npix pixels. stop_at / start_at give the pixel index before
  // which a Stop / Start pulse is issued (-1 = none). rel_commit is pulsed on
  // the cycle the DUT spends committing.
  task automatic send_frame(input int npix, input int stop_at, input int start_at,
                            input logic [1:0] rel_commit);
    bit  cap;
    wr_t w;
    cap = 0;
    if (m_armed) begin
      if (m_skip > 0) m_skip--;
      else if (!m_full[m_ptr]) cap = 1;
      else if (m_drop < 255) m_drop++;
    end
    In_Vs = 1; tick();
    for (int i = 0; i < npix; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == stop_at) begin
        Stop = 1; tick(); Stop = 0;
        m_armed = 0; cap = 0;
        check("busy_after_stop", 32'(Busy), 32'd0);
      end
      if (i == start_at) do_start(~m_cont, 5);
      In_Valid = 1;
      In_Pixel = 16'($urandom);
      if (cap) begin
        if (i < FP) begin
          w.bank = m_ptr; w.addr = AW'(i); w.data = In_Pixel;
          wr_q.push_back(w);
        end else begin
          m_ovf = 1;
        end
      end
      tick();
      In_Valid = 0;
    end
    tick();
    In_Vs = 0; tick();
    Rel_Bank = rel_commit; tick(); Rel_Bank = 2'b00;
    m_full = m_full & ~rel_commit;
    if (cap) begin
      m_full[m_ptr] = 1'b1;
      if (npix < FP) m_short = 1;
      done_q.push_back('{bank: m_ptr, short_f: m_short});
      m_ptr = ~m_ptr;
      if (!m_cont) m_armed = 0;
    end
    tick(); tick();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"},      32'(Busy),        32'(m_armed));
    check({tag, "_bank_full"}, 32'(Bank_Full),   32'(m_full));
    check({tag, "_drop_cnt"},  32'(Drop_Cnt),    32'(m_drop));
    check({tag, "_ovf"},       32'(Ovf),         32'(m_ovf));
    check({tag, "_short"},     32'(Short_Frame), 32'(m_short));
  endtask

  initial begin
    wr_t w;
    model_reset();
    tick();
    check("reset_outputs",
          32'({Wr_En, Wr_Bank, Wr_Addr, Wr_Data, Frame_Done, Done_Bank,
               Short_Frame, Ovf, Drop_Cnt, Bank_Full, Busy}), 32'd0);
    do_reset();
    check_status("reset");

    // 1: skip two frames, capture the third single-shot, ignore the fourth.
    do_start(0, 2);
    for (int f = 0; f < 4; f++) begin
      send_frame(8, -1, -1, 2'b00);
      check_status("t1");
    end
    check("t1_bank_full", 32'(Bank_Full), 32'h1);
    check("t1_busy", 32'(Busy), 32'd0);

    // 2: continuous, no releases: two captures, two drops, then release bank 0.
    do_reset();
    do_start(1, 0);
    for (int f = 0; f < 4; f++) begin
      send_frame(8, -1, -1, 2'b00);
      check_status("t2");
    end
    check("t2_drop_cnt", 32'(Drop_Cnt), 32'd2);
    check("t2_bank_full", 32'(Bank_Full), 32'h3);
    do_release(2'b01);
    send_frame(8, -1, -1, 2'b00);
    check_status("t2_after_release");

    // 3: overflow then short frame.
    do_reset();
    do_start(1, 0);
    send_frame(10, -1, -1, 2'b00);
    check_status("t3_ovf");
    check("t3_ovf_set", 32'(Ovf), 32'd1);
    check("t3_short_clear", 32'(Short_Frame), 32'd0);
    send_frame(5, -1, -1, 2'b00);
    check_status("t3_short");
    check("t3_short_set", 32'(Short_Frame), 32'd1);

    // 4: Stop after three pixels, then recapture into the same bank.
    do_reset();
    do_start(0, 0);
    send_frame(8, 3, -1, 2'b00);
    check_status("t4_stop");
    do_start(0, 0);
    send_frame(8, -1, -1, 2'b00);
    check_status("t4_restart");

    // 5: release racing commit of bank 1; Start during capture is ignored.
    do_reset();
    do_start(1, 0);
    send_frame(8, -1, -1, 2'b00);
    send_frame(8, -1, 2, 2'b10);
    check_status("t5_race");
    check("t5_bank1_full", 32'(Bank_Full[1]), 32'd1);
    do_release(2'b11);
    send_frame(8, -1, -1, 2'b00);
    check_status("t5_mode_kept");

    // 6: asynchronous reset in the middle of a capture.
    do_reset();
    do_start(0, 0);
    In_Vs = 1; tick();
    for (int i = 0; i < 3; i++) begin
      In_Valid = 1; In_Pixel = 16'hA5A5 | 16'($urandom);
      w.bank = 1'b0; w.addr = AW'(i); w.data = In_Pixel;
      wr_q.push_back(w);
      tick();
      In_Valid = 0;
    end
    tick(); tick();
    check("t6_busy_before_reset", 32'(Busy), 32'd1);
    Rst_n = 0;
    #2;
    check("t6_async_reset_outputs",
          32'({Wr_En, Wr_Bank, Wr_Addr, Wr_Data, Frame_Done, Done_Bank,
               Short_Frame, Ovf, Drop_Cnt, Bank_Full, Busy}), 32'd0);
    check("t6_wr_data_zero", 32'(Wr_Data), 32'd0);
    tick();
    Rst_n = 1;
    model_reset();
    In_Vs = 0; tick(); tick();
    send_frame(8, -1, -1, 2'b00);
    check_status("t6_no_start");
    do_start(0, 0);
    send_frame(8, -1, -1, 2'b00);
    check_status("t6_after_start");

    // Randomized mix of starts, releases, frame sizes, stops.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int npix, stop_at, start_at;
      logic [1:0] rc;
      if ($urandom_range(0, 2) == 0) do_start(1'($urandom), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) do_release(2'($urandom));
      npix     = $urandom_range(5, 10);
      stop_at  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : -1;
      start_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      rc       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      send_frame(npix, stop_at, start_at, rc);
      check_status("rand");
    end

    repeat (5) tick();
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    finished = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    if (!finished) begin
      failures++;
      $display("FAIL timeout: got no completion expected completion within bound");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule
